// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus-condition front end: default widths,
// the idle line level and the bundle of single-cycle bus events.
package i2c_pkg;

  localparam int FILT_W_DEF = 4;
  localparam int TMO_W_DEF  = 20;

  // Both lines idle high; synchronisers and filters reset to this level.
  localparam logic LINE_IDLE = 1'b1;

  typedef struct packed {
    logic scl_rising;
    logic scl_faling;
    logic sta;
    logic sto;
  } bus_ev_t;

  // Decodes bus events from the current and previous filtered levels.
  function automatic bus_ev_t decode_ev(input logic en,
                                        input logic scl_now, input logic scl_prev,
                                        input logic sda_now, input logic sda_prev);
    bus_ev_t ev;
    ev.scl_rising = en & scl_now & ~scl_prev;
    ev.scl_faling = en & ~scl_now & scl_prev;
    ev.sta        = en & scl_now & scl_prev & sda_prev & ~sda_now;
    ev.sto        = en & scl_now & scl_prev & ~sda_prev & sda_now;
    return ev;
  endfunction

endpackage

// File: rtl/i2c_line_filt.sv
// One I2C line: two-flop synchroniser followed by a glitch filter that
// accepts a new level only after filt_len+1 consecutive disagreeing samples.
module i2c_line_filt
  import i2c_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pad,
  input  logic [FILT_W-1:0] filt_len,
  output logic              lvl
);

  logic [1:0]        sync_q;
  logic              sync_lvl;
  logic [FILT_W-1:0] cnt_q;
  logic              lvl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {2{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[0], pad};
    end
  end

  assign sync_lvl = sync_q[1];

  // The >= compare keeps the counter bounded if filt_len shrinks mid-count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl_q <= LINE_IDLE;
      cnt_q <= '0;
    end else if (sync_lvl == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= filt_len) begin
      lvl_q <= ~lvl_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/i2c_bus_cond.sv
// I2C bus-condition detector: filtered SCL/SDA levels, edge and START/STOP
// strobes, bus-busy tracking and an SCL-stuck-low timeout interrupt.
module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF,
  parameter int TMO_W  = TMO_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cr_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [TMO_W-1:0]  tmo_limit,
  input  logic              scl_pad,
  input  logic              sda_pad,
  output logic              scl_f,
  output logic              sda_f,
  output logic              scl_rising,
  output logic              scl_faling,
  output logic              sta,
  output logic              sto,
  output logic              busy,
  output logic              irq_tmo
);

  logic           scl_q;
  logic           sda_q;
  bus_ev_t        ev;
  logic           busy_q;
  logic [TMO_W-1:0] t_q;
  logic [TMO_W-1:0] t_inc;
  logic           t_sat;
  logic           tmo_arm;
  logic           tmo_hit;
  logic           irq_q;

  // Filters run independently of cr_en so levels are valid at enable.
  i2c_line_filt #(.FILT_W(FILT_W)) u_scl_filt (
    .clk      (clk),
    .rstn     (rstn),
    .pad      (scl_pad),
    .filt_len (filt_len),
    .lvl      (scl_f)
  );

  i2c_line_filt #(.FILT_W(FILT_W)) u_sda_filt (
    .clk      (clk),
    .rstn     (rstn),
    .pad      (sda_pad),
    .filt_len (filt_len),
    .lvl      (sda_f)
  );

  // Idle reset values match the filter reset, so reset release is silent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q <= LINE_IDLE;
      sda_q <= LINE_IDLE;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign ev = decode_ev(cr_en, scl_f, scl_q, sda_f, sda_q);

  assign scl_rising = ev.scl_rising;
  assign scl_faling = ev.scl_faling;
  assign sta        = ev.sta;
  assign sto        = ev.sto;

  // Timeout runs only while an enabled, busy bus has SCL held low.
  assign tmo_arm = cr_en & busy_q & ~scl_f & (tmo_limit != '0);
  assign t_sat   = &t_q;
  assign t_inc   = t_sat ? t_q : t_q + 1'b1;
  assign tmo_hit = tmo_arm & (t_inc == tmo_limit) & (t_q != tmo_limit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_q <= '0;
    end else if (!tmo_arm) begin
      t_q <= '0;
    end else begin
      t_q <= t_inc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= tmo_hit;
    end
  end

  // Busy drops on the same edge that raises irq_tmo.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
    end else if (!cr_en) begin
      busy_q <= 1'b0;
    end else if (ev.sto || tmo_hit) begin
      busy_q <= 1'b0;
    end else if (ev.sta) begin
      busy_q <= 1'b1;
    end
  end

  assign busy    = busy_q;
  assign irq_tmo = irq_q;

endmodule

// File: tb/tb_i2c_bus_cond.sv
// Bench for i2c_bus_cond: directed bus scenarios against a sample-window
// model of the line filters plus bus-rule model, checked every cycle.
`timescale 1ns/1ps
module tb_i2c_bus_cond;

  localparam int FW = 4;
  localparam int TW = 20;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cr_en = 1'b0;
  logic [FW-1:0] filt_len = '0;
  logic [TW-1:0] tmo_limit = '0;
  logic          scl_pad = 1'b1;
  logic          sda_pad = 1'b1;

  logic scl_f, sda_f, scl_rising, scl_faling, sta, sto, busy, irq_tmo;

  always #5 clk = ~clk;

  i2c_bus_cond #(.FILT_W(FW), .TMO_W(TW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cr_en      (cr_en),
    .filt_len   (filt_len),
    .tmo_limit  (tmo_limit),
    .scl_pad    (scl_pad),
    .sda_pad    (sda_pad),
    .scl_f      (scl_f),
    .sda_f      (sda_f),
    .scl_rising (scl_rising),
    .scl_faling (scl_faling),
    .sta        (sta),
    .sto        (sto),
    .busy       (busy),
    .irq_tmo    (irq_tmo)
  );

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pad sample history, newest in bit 0; the filter sees a pad sample two
  // edges late, and flips when the last filt_len+1 of those all disagree.
  logic [31:0] scl_hist, sda_hist;
  logic m_scl_f, m_sda_f, m_scl_q, m_sda_q, m_busy, m_irq;
  int   m_low;
  logic m_rise, m_fal, m_sta, m_sto, m_run;

  function automatic logic filt_next(input logic [31:0] h, input logic f, input int n);
    logic all_diff;
    all_diff = 1'b1;
    for (int i = 0; i <= n; i++) if (h[i+2] == f) all_diff = 1'b0;
    return all_diff ? ~f : f;
  endfunction

  assign m_rise = cr_en & m_scl_f & ~m_scl_q;
  assign m_fal  = cr_en & ~m_scl_f & m_scl_q;
  assign m_sta  = cr_en & m_scl_f & m_scl_q & m_sda_q & ~m_sda_f;
  assign m_sto  = cr_en & m_scl_f & m_scl_q & ~m_sda_q & m_sda_f;
  assign m_run  = cr_en & m_busy & ~m_scl_f & (tmo_limit != '0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_hist <= '1;
      sda_hist <= '1;
      m_scl_f  <= 1'b1;
      m_sda_f  <= 1'b1;
      m_scl_q  <= 1'b1;
      m_sda_q  <= 1'b1;
      m_busy   <= 1'b0;
      m_irq    <= 1'b0;
      m_low    <= 0;
    end else begin
      scl_hist <= {scl_hist[30:0], scl_pad};
      sda_hist <= {sda_hist[30:0], sda_pad};
      m_scl_f  <= filt_next({scl_hist[30:0], scl_pad}, m_scl_f, int'(filt_len));
      m_sda_f  <= filt_next({sda_hist[30:0], sda_pad}, m_sda_f, int'(filt_len));
      m_scl_q  <= m_scl_f;
      m_sda_q  <= m_sda_f;
      m_low    <= m_run ? m_low + 1 : 0;
      m_irq    <= m_run && (m_low + 1 == int'(tmo_limit));
      if (!cr_en) m_busy <= 1'b0;
      else if (m_sto || (m_run && (m_low + 1 == int'(tmo_limit)))) m_busy <= 1'b0;
      else if (m_sta) m_busy <= 1'b1;
    end
  end

  // ---------------- compare process + pulse counters ----------------
  int n_rise = 0, n_fal = 0, n_sta = 0, n_sto = 0, n_irq = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("scl_f", scl_f, m_scl_f);
      check("sda_f", sda_f, m_sda_f);
      check("scl_rising", scl_rising, m_rise);
      check("scl_faling", scl_faling, m_fal);
      check("sta", sta, m_sta);
      check("sto", sto, m_sto);
      check("busy", busy, m_busy);
      check("irq_tmo", irq_tmo, m_irq);
    end
    n_rise <= n_rise + int'(scl_rising);
    n_fal  <= n_fal + int'(scl_faling);
    n_sta  <= n_sta + int'(sta);
    n_sto  <= n_sto + int'(sto);
    n_irq  <= n_irq + int'(irq_tmo);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       sel = sta;
      1:       sel = sto;
      2:       sel = scl_rising;
      3:       sel = scl_faling;
      default: sel = irq_tmo;
    endcase
  endfunction

  // Counts clock edges until the chosen strobe is seen; -1 if the budget expires.
  task automatic wait_edges(input int which, input int budget, output int edges);
    edges = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #2;
      if (sel(which)) begin
        edges = k;
        break;
      end
    end
  endtask

  // Nine SCL clocks, MSB first; data changes mid-way through SCL low.
  task automatic send_bits(input logic [8:0] bits);
    for (int i = 8; i >= 0; i--) begin
      scl_pad = 1'b0; step(8);
      sda_pad = bits[i]; step(8);
      scl_pad = 1'b1; step(16);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int e;
    int r0, f0, s0, p0, i0;

    filt_len = 4'd3;
    tmo_limit = '0;
    cr_en = 1'b1;
    #1 rstn = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #2;
    check("rst_scl_f", scl_f, 1'b1);
    check("rst_sda_f", sda_f, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", irq_tmo, 1'b0);
    check("rst_strobes", {scl_rising, scl_faling, sta, sto}, 4'b0000);
    step(2);
    rstn = 1'b1;
    step(10);

    // Glitch suppression: 3-cycle low is dropped, 4-cycle low is accepted.
    r0 = n_rise; f0 = n_fal;
    scl_pad = 1'b0; step(3); scl_pad = 1'b1; step(20);
    check("glitch3_fal", n_fal - f0, 0);
    check("glitch3_scl_f", scl_f, 1'b1);
    scl_pad = 1'b0; step(4); scl_pad = 1'b1; step(20);
    check("pulse4_fal", n_fal - f0, 1);
    check("pulse4_rise", n_rise - r0, 1);

    // START latency and busy, then one byte + ACK, then STOP.
    s0 = n_sta;
    sda_pad = 1'b0;
    wait_edges(0, 20, e);
    check("start_lat", e, 6);
    @(posedge clk); #2;
    check("start_busy", busy, 1'b1);
    step(8);
    r0 = n_rise; f0 = n_fal; p0 = n_sto;
    send_bits({8'hA5, 1'b0});
    sda_pad = 1'b1; step(20);
    check("byte_rise", n_rise - r0, 9);
    check("byte_fal", n_fal - f0, 9);
    check("byte_sto", n_sto - p0, 1);
    check("byte_sta", n_sta - s0, 1);
    check("stop_busy", busy, 1'b0);

    // Simultaneous SCL and SDA change: edge strobe only.
    r0 = n_rise; f0 = n_fal; s0 = n_sta; p0 = n_sto;
    scl_pad = 1'b0; sda_pad = 1'b0; step(20);
    check("simul_fal", n_fal - f0, 1);
    check("simul_sta", n_sta - s0, 0);
    scl_pad = 1'b1; sda_pad = 1'b1; step(20);
    check("simul_rise", n_rise - r0, 1);
    check("simul_sto", n_sto - p0, 0);

    // SCL stuck low with timeout 100.
    tmo_limit = 20'd100; i0 = n_irq;
    sda_pad = 1'b0;
    wait_edges(0, 20, e);
    step(8);
    scl_pad = 1'b0;
    wait_edges(3, 20, e);
    check("tmo_fal_lat", e, 6);
    wait_edges(4, 300, e);
    check("tmo_lat", e, 100);
    check("tmo_busy", busy, 1'b0);
    step(150);
    check("tmo_single", n_irq - i0, 1);
    scl_pad = 1'b1; step(16);
    sda_pad = 1'b1; step(20);

    // Timeout disabled.
    tmo_limit = '0; i0 = n_irq;
    sda_pad = 1'b0; step(16);
    scl_pad = 1'b0; step(300);
    check("tmo0_irq", n_irq - i0, 0);
    check("tmo0_busy", busy, 1'b1);
    scl_pad = 1'b1; step(16);
    sda_pad = 1'b1; step(20);
    check("tmo0_stop_busy", busy, 1'b0);

    // Disable mid-transfer: strobes silent, busy stays low until a new START.
    sda_pad = 1'b0; step(16);
    check("en_start_busy", busy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      scl_pad = 1'b0; step(8); scl_pad = 1'b1; step(16);
    end
    cr_en = 1'b0;
    r0 = n_rise; f0 = n_fal; s0 = n_sta; p0 = n_sto;
    step(2);
    scl_pad = 1'b0; step(8); scl_pad = 1'b1; step(16);
    sda_pad = 1'b1; step(16); sda_pad = 1'b0; step(16);
    check("dis_rise", n_rise - r0, 0);
    check("dis_fal", n_fal - f0, 0);
    check("dis_sta", n_sta - s0, 0);
    check("dis_sto", n_sto - p0, 0);
    check("dis_busy", busy, 1'b0);
    cr_en = 1'b1; step(4);
    scl_pad = 1'b0; step(8); scl_pad = 1'b1; step(16);
    check("reen_busy", busy, 1'b0);
    check("reen_rise", n_rise - r0, 1);
    sda_pad = 1'b1; step(16);
    check("reen_sto", n_sto - p0, 1);
    sda_pad = 1'b0; step(16);
    check("reen_start_busy", busy, 1'b1);
    sda_pad = 1'b1; step(16);
    check("reen_stop_busy", busy, 1'b0);

    // Asynchronous reset mid-transfer with both pads low.
    sda_pad = 1'b0; step(16);
    scl_pad = 1'b0; step(16);
    rstn = 1'b0; #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_scl_f", scl_f, 1'b1);
    check("mid_rst_sda_f", sda_f, 1'b1);
    step(3);
    rstn = 1'b1;
    s0 = n_sta; p0 = n_sto;
    step(20);
    check("post_rst_sta", n_sta - s0, 0);
    check("post_rst_scl_f", scl_f, 1'b0);
    scl_pad = 1'b1; sda_pad = 1'b1; step(20);
    check("post_rst_sto", n_sto - p0, 0);
    check("post_rst_busy", busy, 1'b0);

    // Minimum filter length: 3-edge latency, single-cycle pulse passes.
    filt_len = '0; step(4);
    r0 = n_rise; f0 = n_fal;
    scl_pad = 1'b0;
    wait_edges(3, 20, e);
    check("f0_lat", e, 3);
    scl_pad = 1'b1; step(10);
    scl_pad = 1'b0; step(1); scl_pad = 1'b1; step(10);
    check("f0_fal", n_fal - f0, 2);
    check("f0_rise", n_rise - r0, 2);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_bus_cond.md
# i2c_bus_cond

Front-end bus-condition detector that sits directly upstream of the I2C slave engine. It synchronises the raw SCL/SDA pad inputs and removes glitches from them. From the clean levels it produces the single-cycle `sta`, `sto`, `scl_rising` and `scl_faling` strobes the slave engine consumes. It also tracks bus-busy state and flags an SCL-stuck-low timeout.

## Interface
Parameters:
- `FILT_W`, 4: width of the glitch-filter length field and counters.
- `TMO_W`, 20: width of the SCL-low timeout limit and counter.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rstn` in 1: reset, asynchronous, active-low.
- `cr_en` in 1: block enable; when low, all strobes, `busy` and timeout logic are held inactive.
- `filt_len` in FILT_W: glitch-filter length.
  - A line change is accepted after `filt_len+1` consecutive stable cycles.
- `tmo_limit` in TMO_W: SCL-low timeout in clk cycles; 0 disables the timeout.
- `scl_pad` in 1: raw SCL input, asynchronous.
- `sda_pad` in 1: raw SDA input, asynchronous.
- `scl_f` out 1: filtered SCL level.
- `sda_f` out 1: filtered SDA level; drives the slave's `sda_i`.
- `scl_rising` out 1: one-cycle pulse on a filtered SCL 0→1 transition.
- `scl_faling` out 1: one-cycle pulse on a filtered SCL 1→0 transition.
- `sta` out 1: one-cycle pulse on a START or repeated-START condition.
- `sto` out 1: one-cycle pulse on a STOP condition.
- `busy` out 1: bus-busy flag.
- `irq_tmo` out 1: one-cycle pulse when SCL has been held low for `tmo_limit` cycles while `busy`.

## Operation
- **Synchroniser:** a 2-flop chain per line; reset value 1.
- **Filter (per line):**
  - Holds a filtered level `f` (reset 1) and a counter `c` (reset 0).
  - If the synchronised input equals `f`: `c` clears to 0.
  - Otherwise `c` increments. When `c == filt_len`, `f` toggles and `c` clears.
  - The counter never wraps past `filt_len`.
  - A `filt_len` change mid-run takes effect on the next compare.
  - Synchronisers and filters run regardless of `cr_en`, so the levels are valid at enable.
- **Previous levels:** `scl_q` and `sda_q` register the previous `scl_f` and `sda_f`; reset value 1.
- **Strobe equations** (all gated by `cr_en`):
  - `scl_rising = scl_f & ~scl_q`
  - `scl_faling = ~scl_f & scl_q`
  - `sta = scl_f & scl_q & sda_q & ~sda_f`
  - `sto = scl_f & scl_q & ~sda_q & sda_f`
- **Simultaneous SCL and SDA change** in the same cycle: neither `sta` nor `sto` fires. The SCL edge strobe still fires.
- **`busy`** (reset 0):
  - Set on `sta`.
  - Cleared on `sto`, on `irq_tmo`, or when `cr_en` is low.
  - Enabling the block mid-transfer leaves `busy` at 0 until the next `sta`.
- **Timeout counter `t`** (TMO_W bits, reset 0):
  - Clears when `scl_f` is 1, `!busy`, `!cr_en`, or `tmo_limit == 0`.
  - Otherwise increments and saturates at all-ones; it never wraps.
  - `irq_tmo` pulses in the single cycle where `t` transitions to equal `tmo_limit`.
- **Output reset values:** `scl_f`=1, `sda_f`=1, and all strobes, `busy` and `irq_tmo` = 0.

## Timing
- Pad edge to `scl_f`/`sda_f` change: `filt_len+3` clk cycles (2 synchroniser cycles + `filt_len+1` filter cycles).
- A pad pulse shorter than `filt_len+1` cycles, as seen after synchronisation, is fully suppressed.
- Strobes are combinational from registers and coincide with the first cycle of the new filtered level. They are guaranteed one cycle wide.
- `busy` and `t` update on the clock after the strobe.
- `irq_tmo` is asserted `tmo_limit` cycles after the first `scl_f == 0` cycle with `busy` high. On that same edge `busy` drops.
- Asynchronous reset mid-transfer: all state returns to reset values immediately. No `sta` or `sto` is generated by the reset release itself, because the reset values of `scl_q` and `sda_q` equal those of `scl_f` and `sda_f`.

## Structure
- Shared package `i2c_pkg`:
  - Default `FILT_W` and `TMO_W` values.
  - Line idle/reset level constant (1'b1).
- Sub-module `i2c_line_filt`: synchroniser plus glitch filter for one line. Parameter `FILT_W`; ports `clk`, `rstn`, `pad`, `filt_len`, `lvl`. Instantiated twice.
- Top module `i2c_bus_cond`: previous-level registers, strobe logic, `busy` flag and timeout counter.

## Test plan
- `filt_len`=3; drive a START (SDA falls while SCL high) → exactly one `sta` pulse, 6 cycles after the SDA pad edge; `busy`=1 on the next cycle.
- `filt_len`=3; 3-cycle low glitch on SCL while high → no `scl_faling`, `scl_f` stays 1. A 4-cycle pulse → one `scl_faling` then one `scl_rising`.
- Full byte (8 SCL clocks plus ACK) then STOP → 9 `scl_rising`, 9 `scl_faling`, 1 `sto`; `busy` returns to 0.
- SCL and SDA pads toggled on the same clk edge, both high→low → `scl_faling`=1, `sta`=0.
- `tmo_limit`=100; after START, hold SCL low → `irq_tmo` single pulse 100 cycles after `scl_f` falls; `busy`=0; no further pulse while still low. With `tmo_limit`=0 → no pulse.
- Toggle `cr_en` low mid-transfer, then high → strobes suppressed while low; `busy`=0 until the next START; `scl_f`/`sda_f` track the pads throughout.
